// File: rtl/sec_count_pkg.sv
// Shared types and digit limits for the 0-59 seconds counter controller.
package sec_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles while run is high.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] pre;

  assign tick = run & (pre == LAST);

  // Held when run is low so a pause resumes mid-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pre <= '0;
    else if (zero)  pre <= '0;
    else if (run)   pre <= tick ? '0 : pre + W'(1);
  end

endmodule

// File: rtl/sec_count_ctrl.sv
// Run/pause/clear controller for the mod-60 seconds counter: issues count
// enables, latches direction and detects the 00 / 59 terminal conditions.
module sec_count_ctrl
  import sec_count_pkg::*;
#(
  parameter int   TICK_DIV = 50_000_000,
  parameter logic WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       dir_up,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic       running,
  output logic       done,
  output logic       wrap
);

  state_t state, nxt;
  logic   ss_q, ss_rise, dir_lat, done_q;
  logic   tick, run_s, pre_zero;
  logic   at_00, at_01, at_58, at_59;
  logic   down_term, up_term;

  assign ss_rise = start_stop & ~ss_q;
  assign run_s   = (state == RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .reset (reset),
    .run   (run_s),
    .zero  (pre_zero),
    .tick  (tick)
  );

  // Exact compares, so out-of-range digits never match a terminal.
  assign at_00 = (tens == 4'd0)     && (ones == 4'd0);
  assign at_01 = (tens == 4'd0)     && (ones == 4'd1);
  assign at_58 = (tens == TENS_MAX) && (ones == ONES_MAX - 4'd1);
  assign at_59 = (tens == TENS_MAX) && (ones == ONES_MAX);

  assign down_term = ~dir_lat & at_01;
  assign up_term   = dir_lat & ~WRAP & at_58;

  assign cnt_en  = tick & ~clr;
  assign cnt_up  = dir_lat;
  assign cnt_clr = clr;
  assign running = run_s;
  assign done    = done_q;
  assign wrap    = cnt_en & dir_lat & WRAP & at_59;

  always_comb begin
    nxt      = state;
    pre_zero = 1'b0;
    if (clr) begin
      nxt      = IDLE;
      pre_zero = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A start that would immediately sit on a terminal is refused.
          if (ss_rise && !(!dir_up && at_00) && !(dir_up && !WRAP && at_59)) begin
            nxt      = RUN;
            pre_zero = 1'b1;
          end
        end
        RUN: begin
          if (cnt_en && (down_term || up_term)) nxt = DONE;
          else if (ss_rise)                     nxt = PAUSE;
        end
        PAUSE:   if (ss_rise) nxt = RUN;
        DONE:    if (ss_rise) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ss_q    <= 1'b0;
      dir_lat <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state  <= nxt;
      ss_q   <= start_stop;
      done_q <= (nxt == DONE) && (state != DONE);
      if ((nxt == RUN) && (state != RUN)) dir_lat <= dir_up;
    end
  end

endmodule
